// File: rtl/imem_pkg.sv
// Shared types and sizes for the instruction-memory fetch sequencer and its byte RAM.
package imem_pkg;

  localparam int unsigned IMEM_BYTES = 1024;
  localparam int unsigned INST_BYTES = 4;
  localparam int unsigned CNT_W      = $clog2(INST_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    TAIL,
    RESP,
    WR
  } imem_seq_state_t;

endpackage

// File: rtl/imem_byte_ram.sv
// Byte-wide synchronous single-port RAM with 1-cycle read latency; a read in a write
// cycle returns the old contents.
module imem_byte_ram
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  localparam int unsigned Depth = (IMEM_BYTES < (1 << ADDR_W)) ? IMEM_BYTES : (1 << ADDR_W);

  logic [7:0] mem_q [Depth];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_fetch_sequencer.sv
// Arbitrates a byte-wide instruction memory between a byte loader and a 4-byte big-endian
// fetch path. Define IMEM_ALIGN_CHECK_EN to reject misaligned fetches with fetch_err.
module imem_fetch_sequencer
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_rvalid,
  input  logic              fetch_rready,
  output logic [31:0]       fetch_inst,
  output logic              fetch_err,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  imem_seq_state_t   state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [31:0]       inst_q, inst_d;
  logic              err_q, err_d;

  logic unused_fetch_addr;
  assign unused_fetch_addr = ^fetch_addr[31:ADDR_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      inst_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    inst_d       = inst_q;
    err_d        = err_q;
    fetch_ready  = 1'b0;
    load_ready   = 1'b0;
    fetch_rvalid = 1'b0;
    mem_addr     = '0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_wdata    = '0;

    unique case (state_q)
      IDLE: begin
        load_ready  = 1'b1;
        fetch_ready = !load_valid;
        if (load_valid) begin
          waddr_d = load_addr;
          wdata_d = load_data;
          state_d = WR;
        end else if (fetch_valid) begin
          base_d = fetch_addr[ADDR_W-1:0];
          cnt_d  = '0;
`ifdef IMEM_ALIGN_CHECK_EN
          if (fetch_addr[1:0] != 2'b00) begin
            inst_d  = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = RD;
          end
`else
          err_d   = 1'b0;
          state_d = RD;
`endif
        end
      end
      WR: begin
        mem_we    = 1'b1;
        mem_addr  = waddr_q;
        mem_wdata = wdata_q;
        state_d   = IDLE;
      end
      RD: begin
        mem_re   = 1'b1;
        mem_addr = base_q + ADDR_W'(cnt_q);
        // The byte for address base+k-1 arrives while address base+k is issued.
        case (cnt_q)
          2'd1:    inst_d[31:24] = mem_rdata;
          2'd2:    inst_d[23:16] = mem_rdata;
          2'd3:    inst_d[15:8]  = mem_rdata;
          default: ;
        endcase
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(INST_BYTES - 1)) begin
          state_d = TAIL;
        end
      end
      TAIL: begin
        inst_d[7:0] = mem_rdata;
        state_d     = RESP;
      end
      RESP: begin
        fetch_rvalid = 1'b1;
        if (fetch_rready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!rst_n) begin
      fetch_ready  = 1'b0;
      load_ready   = 1'b0;
      fetch_rvalid = 1'b0;
      mem_addr     = '0;
      mem_re       = 1'b0;
      mem_we       = 1'b0;
      mem_wdata    = '0;
    end
  end

  assign fetch_inst = rst_n ? inst_q : 32'h0;
`ifdef IMEM_ALIGN_CHECK_EN
  assign fetch_err  = rst_n & err_q;
`else
  assign fetch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Randomized self-checking bench for imem_fetch_sequencer backed by imem_byte_ram.
module tb_imem_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_addr;
  logic        fetch_rvalid;
  logic        fetch_rready;
  logic [31:0] fetch_inst;
  logic        fetch_err;
  logic        load_valid;
  logic        load_ready;
  logic [9:0]  load_addr;
  logic [7:0]  load_data;
  logic [9:0]  mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] model_mem [1024];

  imem_fetch_sequencer #(.ADDR_W(10)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_valid  (fetch_valid),
    .fetch_ready  (fetch_ready),
    .fetch_addr   (fetch_addr),
    .fetch_rvalid (fetch_rvalid),
    .fetch_rready (fetch_rready),
    .fetch_inst   (fetch_inst),
    .fetch_err    (fetch_err),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .mem_addr     (mem_addr),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  imem_byte_ram #(.ADDR_W(10)) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [9:0] base);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      w[31-8*k -: 8] = model_mem[(int'(base) + k) % 1024];
    end
    return w;
  endfunction

  function automatic bit misaligned_rejected(input logic [31:0] a);
`ifdef IMEM_ALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_load(input logic [9:0] a, input logic [7:0] d);
    int n;
    @(negedge clk);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    #1;
    n = 0;
    while (!load_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!load_ready) begin
      chk("load_timeout", 32'd0, 32'd1);
      load_valid = 1'b0;
      return;
    end
    chk("ld_idle_we", 32'(mem_we), 32'd0);
    model_mem[a] = d;
    @(negedge clk);
    load_valid = 1'b0;
    #1;
    chk("ld_we", 32'(mem_we), 32'd1);
    chk("ld_addr", 32'(mem_addr), 32'(a));
    chk("ld_wdata", 32'(mem_wdata), 32'(d));
    chk("ld_busy_ready", 32'({load_ready, fetch_ready}), 32'd0);
  endtask

  // Issues one fetch and checks the whole transaction, cycle by cycle, against the model.
  task automatic do_fetch(input logic [31:0] a, input int hold, input bit early,
                          output logic [31:0] inst_seen, output int waited);
    logic [9:0]  base;
    logic [31:0] exp;
    bit          rej;
    @(negedge clk);
    fetch_valid  = 1'b1;
    fetch_addr   = a;
    fetch_rready = early;
    #1;
    waited = 0;
    while (!fetch_ready && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    inst_seen = 32'hx;
    if (!fetch_ready) begin
      chk("fetch_timeout", 32'd0, 32'd1);
      fetch_valid = 1'b0;
      return;
    end
    base = a[9:0];
    rej  = misaligned_rejected(a);
    exp  = rej ? 32'h0 : model_word(base);
    chk("f_idle_rvalid", 32'(fetch_rvalid), 32'd0);
    if (!rej) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        fetch_valid = 1'b0;
        #1;
        chk("f_rd_re", 32'(mem_re), 32'd1);
        chk("f_rd_addr", 32'(mem_addr), 32'((int'(base) + i) % 1024));
        chk("f_rd_busy", 32'({fetch_rvalid, fetch_ready, load_ready}), 32'd0);
      end
      @(negedge clk);
      #1;
      chk("f_tail_quiet", 32'({mem_re, mem_we, fetch_rvalid}), 32'd0);
    end
    @(negedge clk);
    fetch_valid = 1'b0;
    #1;
    chk("f_rvalid", 32'(fetch_rvalid), 32'd1);
    chk("f_inst", fetch_inst, exp);
    chk("f_err", 32'(fetch_err), 32'(rej));
    chk("f_resp_mem_quiet", 32'({mem_re, mem_we, mem_addr}), 32'd0);
    inst_seen = fetch_inst;
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        #1;
        chk("f_hold_rvalid", 32'(fetch_rvalid), 32'd1);
        chk("f_hold_inst", fetch_inst, exp);
        chk("f_hold_err", 32'(fetch_err), 32'(rej));
      end
      @(negedge clk);
      fetch_rready = 1'b1;
      #1;
      chk("f_release_rvalid", 32'(fetch_rvalid), 32'd1);
    end
    @(negedge clk);
    fetch_rready = 1'b0;
    #1;
    chk("f_after_rvalid", 32'(fetch_rvalid), 32'd0);
    chk("f_after_ready", 32'(fetch_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] got;
    int          waited;
    logic [7:0]  d;

    rst_n        = 1'b0;
    fetch_valid  = 1'b1;
    fetch_addr   = 32'h0;
    fetch_rready = 1'b0;
    load_valid   = 1'b1;
    load_addr    = '0;
    load_data    = '0;

    // Reset state: everything gated to zero even with requests pending.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rst_ctrl", 32'({fetch_ready, load_ready, fetch_rvalid, mem_re, mem_we}), 32'd0);
      chk("rst_data", fetch_inst | 32'(mem_addr) | 32'(mem_wdata) | 32'(fetch_err), 32'd0);
    end
    @(negedge clk);
    fetch_valid = 1'b0;
    load_valid  = 1'b0;
    rst_n       = 1'b1;
    #1;
    chk("post_rst_ready", 32'({fetch_ready, load_ready}), 32'b11);

    for (int a = 0; a < 1024; a++) begin
      do_load(10'(a), 8'($urandom));
    end

    // Directed: basic big-endian assembly.
    do_load(10'd0, 8'h12);
    do_load(10'd1, 8'h34);
    do_load(10'd2, 8'h56);
    do_load(10'd3, 8'h78);
    do_fetch(32'd0, 0, 1'b0, got, waited);
    chk("t_basic_word", got, 32'h12345678);

    // Directed: simultaneous requests, load wins.
    d = 8'($urandom);
    @(negedge clk);
    load_valid  = 1'b1;
    load_addr   = 10'd5;
    load_data   = d;
    fetch_valid = 1'b1;
    fetch_addr  = 32'd4;
    #1;
    chk("arb_load_ready", 32'(load_ready), 32'd1);
    chk("arb_fetch_ready", 32'(fetch_ready), 32'd0);
    model_mem[5] = d;
    @(negedge clk);
    load_valid = 1'b0;
    #1;
    chk("arb_wr_we", 32'(mem_we), 32'd1);
    chk("arb_wr_fready", 32'(fetch_ready), 32'd0);
    do_fetch(32'd4, 0, 1'b0, got, waited);
    chk("arb_accept_delay", 32'(waited), 32'd0);
    chk("arb_new_byte", 32'(got[23:16]), 32'(d));

    // Directed: wrap-around at the top of memory.
    do_load(10'd1022, 8'hAA);
    do_load(10'd1023, 8'hBB);
    do_load(10'd0, 8'hCC);
    do_load(10'd1, 8'hDD);
    do_fetch(32'd1022, 0, 1'b0, got, waited);
`ifdef IMEM_ALIGN_CHECK_EN
    chk("t_wrap_word", got, 32'h0);
`else
    chk("t_wrap_word", got, 32'hAABBCCDD);
`endif

    // Directed: response held for 7 cycles.
    do_fetch(32'd8, 7, 1'b0, got, waited);

    // Directed: reset abandons a fetch during RD with cnt = 2.
    @(negedge clk);
    fetch_valid = 1'b1;
    fetch_addr  = 32'd16;
    #1;
    chk("rst_fetch_accept", 32'(fetch_ready), 32'd1);
    @(negedge clk);
    fetch_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", 32'({fetch_ready, load_ready, fetch_rvalid, mem_re, mem_we}), 32'd0);
    chk("midrst_data", 32'(mem_addr) | 32'(mem_wdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_idle", 32'({fetch_ready, load_ready, fetch_rvalid, mem_re}), 32'b1100);
    chk("midrst_inst", fetch_inst, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      chk("midrst_no_resp", 32'(fetch_rvalid), 32'd0);
    end
    do_fetch(32'd4, 1, 1'b0, got, waited);

    // Directed: back-to-back load stream.
    for (int i = 0; i < 8; i++) begin
      do_load(10'($urandom), 8'($urandom));
    end

    // Randomized mix of loads and fetches with varied response back-pressure.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_load(10'($urandom), 8'($urandom));
      end else begin
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
        do_fetch(a, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), got, waited);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_fetch_sequencer.md
# imem_fetch_sequencer

Sequences and arbitrates a single-port, byte-wide, 1024-byte instruction memory between the CPU fetch path and a byte loader (boot/program download). A fetch reads four consecutive bytes and assembles a 32-bit big-endian instruction: the byte at the lowest address is the MSB. Load writes are single bytes. The block sits between the PC/fetch logic and the instruction memory array, replacing direct combinational word reads.

## Interface
- ADDR_W, 10, byte-address width of the memory (1024 bytes)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- fetch_valid  in  1  fetch request
- fetch_ready  out  1  fetch request accepted this cycle
- fetch_addr  in  32  byte address of instruction; only [ADDR_W-1:0] used
- fetch_rvalid  out  1  instruction response valid
- fetch_rready  in  1  consumer accepts response
- fetch_inst  out  32  assembled instruction
- fetch_err  out  1  misaligned-fetch flag, qualified by fetch_rvalid
- load_valid  in  1  byte write request
- load_ready  out  1  write request accepted this cycle
- load_addr  in  ADDR_W  byte address to write
- load_data  in  8  byte to write
- mem_addr  out  ADDR_W  memory byte address
- mem_re  out  1  memory read enable
- mem_we  out  1  memory write enable
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data, valid one cycle after mem_re

## Operation
- FSM states: IDLE, RD, TAIL, RESP, WR. A 2-bit counter `cnt` is used in RD.
- IDLE:
  - load_ready = 1.
  - fetch_ready = !load_valid. The loader has fixed priority, evaluated only in IDLE; there is no preemption.
  - Load accepted: latch addr and data, go to WR.
  - Fetch accepted: latch base = fetch_addr[ADDR_W-1:0], cnt = 0, go to RD.
- WR (1 cycle): mem_we = 1, mem_addr = latched addr, mem_wdata = latched data; then return to IDLE.
- RD (4 cycles, cnt 0..3):
  - mem_re = 1, mem_addr = base + cnt, modulo 2^ADDR_W (wraps 1023 → 0).
  - cnt = 3 goes to TAIL.
- Byte capture: mem_rdata is captured into instruction byte k (k = 0 is bits [31:24]) in the cycle after address base+k is issued. Bytes 0–2 are captured in RD; byte 3 is captured in TAIL.
- TAIL (1 cycle): captures byte 3, then goes to RESP.
- RESP:
  - fetch_rvalid = 1. fetch_inst and fetch_err are held stable until fetch_rready.
  - On fetch_rready, return to IDLE. The next request is accepted no earlier than the following cycle.
- Outside WR and RD, mem_re, mem_we, mem_addr and mem_wdata are 0.
- Both ready outputs are 0 outside IDLE. Requests arriving then simply wait, since valid must be held.
- Requester rules: valid must stay asserted, with address and data stable, until ready.

## Timing
- While rst_n = 0 at a clock edge, the state goes to IDLE and cnt, fetch_inst, fetch_err and the latches go to 0. In the reset cycle all outputs are 0 (ready outputs are gated by rst_n).
- Reset mid-fetch or mid-write:
  - The operation is abandoned and no response is produced.
  - A write already in the WR cycle is not retried.
- Fetch latency: accept edge E0, RD during E0..E4, TAIL, then fetch_rvalid high after edge E5 (5 cycles). Minimum fetch period is 6 cycles.
- Load: 1 write per 2 cycles.
- If load_valid and fetch_valid are both asserted in IDLE, the load wins; the fetch is accepted in the next IDLE if load_valid is then low.
- fetch_rready may be high before fetch_rvalid; RESP then lasts exactly 1 cycle.

## Configuration
- IMEM_ALIGN_CHECK_EN defined:
  - A fetch with fetch_addr[1:0] != 0 is accepted, performs no memory access, and goes IDLE → RESP.
  - fetch_rvalid is then high 1 cycle after the accept edge, with fetch_inst = 0 and fetch_err = 1.
  - Aligned fetches behave as normal with fetch_err = 0.
- IMEM_ALIGN_CHECK_EN undefined:
  - fetch_err is tied to 0.
  - Misaligned addresses are fetched as bytes base..base+3, with wrap-around.

## Structure
- Shared package `imem_pkg`:
  - typedef enum `imem_seq_state_t` (IDLE, RD, TAIL, RESP, WR)
  - localparam IMEM_BYTES = 1024
  - localparam INST_BYTES = 4
- Optional sub-module `imem_byte_ram`: a 1024×8 synchronous single-port RAM (1-cycle read, write-first disabled) used by the bench and by the top level. The sequencer itself contains no storage array.

## Test plan
- Load bytes 0x12, 0x34, 0x56, 0x78 to addresses 0..3, then fetch addr 0 → fetch_inst = 0x12345678 exactly 5 cycles after accept; mem_re high for 4 cycles on addresses 0, 1, 2, 3.
- load_valid and fetch_valid raised in the same IDLE cycle → load_ready = 1, fetch_ready = 0; the fetch is accepted 2 cycles later and returns the newly written byte.
- Bytes 0xAA at 1022, 0xBB at 1023, 0xCC at 0, 0xDD at 1, then fetch addr 1022 → 0xAABBCCDD (address wrap-around). With IMEM_ALIGN_CHECK_EN defined, this case instead yields fetch_err = 1 and inst = 0 after 1 cycle.
- Hold fetch_rready low for 7 cycles in RESP → fetch_rvalid and fetch_inst stay stable; release → IDLE next cycle, fetch_ready = 1.
- Drive rst_n low during RD with cnt = 2 → next cycle all outputs are 0 and the state is IDLE. No fetch_rvalid ever appears for the abandoned fetch, and a subsequent fetch of addr 4 returns the correct word.
- Stream 8 back-to-back loads → exactly one mem_we pulse every 2 cycles, with mem_addr and mem_wdata matching each request.
